// File: rtl/vending_machine_ctrl.sv
// Multi-product vending controller: accumulates coin credit, vends one of N_ITEMS
// priced products, and returns change to the hopper through a valid/ack handshake.
module vending_machine_ctrl #(
  parameter int unsigned W          = 8,
  parameter int unsigned N_ITEMS    = 4,
  // Item i lives at PRICES[i*W +: W]; item 0 (price 100) sits in the low byte.
  parameter logic [N_ITEMS*W-1:0] PRICES = {8'd25, 8'd50, 8'd75, 8'd100},
  parameter logic [W-1:0] MAX_CREDIT = 8'd255,
  localparam int unsigned SW        = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [W-1:0]  coin_val,
  output logic          coin_ready,
  output logic          coin_reject,
  input  logic          sel_valid,
  input  logic [SW-1:0] sel,
  output logic          sel_err,
  input  logic          cancel,
  output logic [W-1:0]  credit,
  output logic          dispense,
  output logic [SW-1:0] disp_item,
  output logic          change_valid,
  output logic [W-1:0]  change_val,
  input  logic          change_ack
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  credit_q, credit_d;
  logic [SW-1:0] item_q, item_d;
  logic [W-1:0]  change_val_q, change_val_d;
  logic          coin_reject_q, coin_reject_d;
  logic          sel_err_q, sel_err_d;
  logic          dispense_q, dispense_d;
  logic          coin_ready_q, coin_ready_d;
  logic          change_valid_q, change_valid_d;

  logic [W:0]    sum;
  logic          coin_fits;
  logic [W-1:0]  eff_credit;
  logic [W-1:0]  price;
  logic          sel_known;

  // Price lookup; an index with no matching item is flagged as unknown.
  always_comb begin
    price     = '0;
    sel_known = 1'b0;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (sel == SW'(i)) begin
        price     = PRICES[i*W +: W];
        sel_known = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    item_d        = item_q;
    change_val_d  = change_val_q;
    coin_reject_d = 1'b0;
    sel_err_d     = 1'b0;

    sum        = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits  = (sum <= {1'b0, MAX_CREDIT});
    eff_credit = (coin_valid && coin_fits) ? sum[W-1:0] : credit_q;

    case (state_q)
      IDLE: begin
        if (cancel && (credit_q != '0)) begin
          state_d       = CHANGE;
          change_val_d  = credit_q;
          credit_d      = '0;
          coin_reject_d = coin_valid;
        end else begin
          coin_reject_d = coin_valid && !coin_fits;
          credit_d      = eff_credit;
          if (sel_valid) begin
            if (!sel_known || (eff_credit < price)) begin
              sel_err_d = 1'b1;
            end else begin
              item_d   = sel;
              credit_d = eff_credit - price;
              state_d  = VEND;
            end
          end
        end
      end
      VEND: begin
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
          state_d      = CHANGE;
          change_val_d = credit_q;
          credit_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_ack) begin
          state_d      = IDLE;
          change_val_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    dispense_d     = (state_d == VEND);
    coin_ready_d   = (state_d == IDLE);
    change_valid_d = (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      item_q         <= '0;
      change_val_q   <= '0;
      coin_reject_q  <= 1'b0;
      sel_err_q      <= 1'b0;
      dispense_q     <= 1'b0;
      coin_ready_q   <= 1'b0;
      change_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      item_q         <= item_d;
      change_val_q   <= change_val_d;
      coin_reject_q  <= coin_reject_d;
      sel_err_q      <= sel_err_d;
      dispense_q     <= dispense_d;
      coin_ready_q   <= coin_ready_d;
      change_valid_q <= change_valid_d;
    end
  end

  assign coin_ready   = coin_ready_q;
  assign coin_reject  = coin_reject_q;
  assign sel_err      = sel_err_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign disp_item    = item_q;
  assign change_valid = change_valid_q;
  assign change_val   = change_val_q;

endmodule
